btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Conditions the raw Nexys A7 push-button pins before they reach the SweRVolf core's push-button GPIO input.
- Per button: 2-flop synchronizer, counter-based debouncer, press/release edge pulses and a sticky event flag.
- Sticky flags are software-clearable and are ORed into a level interrupt.
- Runs in the core clock domain (50 MHz).

Parameters:
- N_BTN, 5, number of buttons conditioned.
- DB_CYCLES, 500000, cycles the synchronized input must hold a new value before it is accepted (10 ms at 50 MHz); legal range >= 2.
- CW, $clog2(DB_CYCLES), debounce counter width (derived; not overridden).

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-high reset.
- i_btn  input  N_BTN  raw button pins, asynchronous to clk.
- i_clr_we  input  1  clear strobe for sticky events.
- i_clr_mask  input  N_BTN  events to clear when i_clr_we=1.
- i_irq_en  input  N_BTN  per-button interrupt enable.
- o_level  output  N_BTN  debounced button level.
- o_press  output  N_BTN  one-cycle pulse on an accepted 0->1 transition.
- o_release  output  N_BTN  one-cycle pulse on an accepted 1->0 transition.
- o_event  output  N_BTN  sticky press flags.
- o_irq  output  1  |(o_event & i_irq_en), registered.

Behaviour:
- Reset (async assert, sync release): all outputs 0; sync flops 0; counters 0; every channel in STABLE_LO.
- Synchronizer: s1 <= i_btn; s2 <= s1. Only s2 is used downstream.
- Per-channel FSM, states STABLE_LO, PEND_HI, STABLE_HI, PEND_LO:
  - STABLE_LO: s2=1 -> PEND_HI with cnt<=1; else cnt<=0.
  - PEND_HI: s2=0 -> STABLE_LO with cnt<=0 (glitch rejected, no pulse). If s2=1 and cnt==DB_CYCLES-1 -> STABLE_HI, level<=1, press<=1, cnt<=0. Otherwise cnt<=cnt+1.
  - STABLE_HI and PEND_LO mirror the above with the polarities inverted, emitting a release pulse.
- Latency: the edge that first samples a new i_btn value is e0. o_level and o_press change at edge e0+DB_CYCLES+1, provided the input stays stable throughout.
- Glitch rule: a pulse held for at most DB_CYCLES-1 synchronized cycles never changes o_level.
- o_press and o_release are high for exactly one cycle per accepted transition and are never high simultaneously on the same channel.
- Sticky event, per bit i:
  - Set when press[i] is asserted.
  - Otherwise cleared when i_clr_we & i_clr_mask[i].
  - Set wins over clear on the same edge.
  - Holds while i_clr_we=0 regardless of i_clr_mask.
- o_irq is registered from the updated event value, so it asserts one cycle after the event bit sets and deasserts one cycle after the clear.
- Counter arithmetic: the counter is unsigned CW bits and never exceeds DB_CYCLES-1, so it cannot wrap.
- Reset asserted mid-debounce: the channel aborts immediately to STABLE_LO. A button still held after reset release produces a fresh press after the full latency.
- Channels are fully independent; simultaneous transitions on several buttons yield simultaneous pulses.

Decomposition:
- Package btn_pkg holds:
  - the enum db_state_t {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO};
  - the default-DB_CYCLES localparam for 50 MHz.
- Sub-module btn_debounce_ch: single-channel synchronizer, FSM and counter, producing level/press/release.
- The top instantiates btn_debounce_ch N_BTN times in a generate loop and owns the event, clear and irq logic.

Test Plan (DB_CYCLES=4, N_BTN=5):
- Reset with i_btn=5'b11111, release rst, hold inputs -> all outputs 0 during reset; o_level=5'b11111 and o_press=5'b11111 for one cycle at e0+5, where e0 is the first sampling edge after release.
- i_btn[0] high for 3 cycles, then low -> o_level[0], o_press[0] and o_event[0] stay 0 throughout.
- i_btn[2] rises and holds, i_irq_en=5'b00100 -> o_press[2]=1 for 1 cycle at e0+5, o_event=5'b00100 at the same edge, o_irq=1 one cycle later; i_btn[2] falls -> o_release[2] pulses at e0'+5 and o_event stays set.
- Clear with event[2] set: i_clr_we=1, i_clr_mask=5'b00100 -> o_event=0 next edge, o_irq=0 one cycle after; repeat with i_clr_we=1 on the same cycle as a new press[2] -> o_event[2] remains 1.
- rst pulsed while channel 1 is in PEND_HI with cnt=2 -> o_level[1]=0 and no press pulse; with the input still high after release, the press arrives at e0+5.
- i_btn[3] and i_btn[4] rise on the same edge -> o_press=5'b11000 in a single cycle; o_release=0.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioning path.
package btn_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } db_state_t;

    // 10 ms hold time at the 50 MHz core clock.
    localparam int DB_CYCLES_50MHZ = 500000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM with hold counter,
// registered level plus one-cycle press/release pulses.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_50MHZ,
    parameter int CW        = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic press_set
);

    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic      s1_reg;
    logic      s2_reg;
    db_state_t state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic      level_reg, level_next;
    logic      press_reg, press_next;
    logic      release_reg, release_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg      <= 1'b0;
            s2_reg      <= 1'b0;
            state_reg   <= STABLE_LO;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            s1_reg      <= btn;
            s2_reg      <= s1_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            level_reg   <= level_next;
            press_reg   <= press_next;
            release_reg <= release_next;
        end
    end

    // The counter counts consecutive cycles spent in a PEND state; it is
    // cleared on every exit, so it never passes CNT_MAX.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        level_next   = level_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state_reg)
            STABLE_LO: begin
                if (s2_reg) begin
                    state_next = PEND_HI;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            PEND_HI: begin
                if (!s2_reg) begin
                    state_next = STABLE_LO;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = STABLE_HI;
                    level_next = 1'b1;
                    press_next = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s2_reg) begin
                    state_next = PEND_LO;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            PEND_LO: begin
                if (s2_reg) begin
                    state_next   = STABLE_HI;
                    cnt_next     = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next   = STABLE_LO;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                    cnt_next     = '0;
                end else begin
                    cnt_next     = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = STABLE_LO;
                cnt_next   = '0;
            end
        endcase
    end

    assign level         = level_reg;
    assign press         = press_reg;
    assign release_pulse = release_reg;
    // Lets the parent set its sticky flag on the same edge the press registers.
    assign press_set     = press_next;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: per-button debounce channels plus sticky press
// events, software clear and a registered level interrupt.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int   N_BTN     = 5,
    parameter int   DB_CYCLES = DB_CYCLES_50MHZ,
    localparam int  CW        = $clog2(DB_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] i_btn,
    input  logic             i_clr_we,
    input  logic [N_BTN-1:0] i_clr_mask,
    input  logic [N_BTN-1:0] i_irq_en,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_event,
    output logic             o_irq
);

    logic [N_BTN-1:0] press_set;
    logic [N_BTN-1:0] clr;
    logic [N_BTN-1:0] event_reg, event_next;
    logic             irq_reg;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
            btn_debounce_ch #(
                .DB_CYCLES (DB_CYCLES),
                .CW        (CW)
            ) u_ch (
                .clk           (clk),
                .rst           (rst),
                .btn           (i_btn[gi]),
                .level         (o_level[gi]),
                .press         (o_press[gi]),
                .release_pulse (o_release[gi]),
                .press_set     (press_set[gi])
            );
        end
    endgenerate

    // A press landing on the same edge as a clear keeps the flag set.
    assign clr        = i_clr_we ? i_clr_mask : '0;
    assign event_next = press_set | (event_reg & ~clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_reg <= '0;
            irq_reg   <= 1'b0;
        end else begin
            event_reg <= event_next;
            irq_reg   <= |(event_reg & i_irq_en);
        end
    end

    assign o_event = event_reg;
    assign o_irq   = irq_reg;

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomized and directed bench for btn_conditioner with a run-length
// reference model of the debounce and event behaviour.
module tb_btn_conditioner;

    localparam int N  = 5;
    localparam int DB = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] i_btn;
    logic         i_clr_we;
    logic [N-1:0] i_clr_mask;
    logic [N-1:0] i_irq_en;
    logic [N-1:0] o_level, o_press, o_release, o_event;
    logic         o_irq;

    btn_conditioner #(.N_BTN(N), .DB_CYCLES(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_btn      (i_btn),
        .i_clr_we   (i_clr_we),
        .i_clr_mask (i_clr_mask),
        .i_irq_en   (i_irq_en),
        .o_level    (o_level),
        .o_press    (o_press),
        .o_release  (o_release),
        .o_event    (o_event),
        .o_irq      (o_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int fails   = 0;

    // Reference: the synchronized input is i_btn two edges late; a new level
    // is accepted on the DB-th consecutive edge where it differs from level.
    logic [N-1:0] d1, d2, m_level, m_press, m_release, m_event;
    logic         m_irq;
    int           run_len [N];

    task automatic model_clear();
        d1 = '0; d2 = '0; m_level = '0; m_press = '0; m_release = '0;
        m_event = '0; m_irq = 1'b0;
        for (int i = 0; i < N; i++) run_len[i] = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] ev_old;
        ev_old = m_event;
        m_irq  = |(ev_old & i_irq_en);
        for (int i = 0; i < N; i++) begin
            m_press[i]   = 1'b0;
            m_release[i] = 1'b0;
            if (d2[i] != m_level[i]) begin
                run_len[i] = run_len[i] + 1;
                if (run_len[i] == DB) begin
                    m_level[i] = d2[i];
                    if (d2[i]) m_press[i] = 1'b1;
                    else       m_release[i] = 1'b1;
                    run_len[i] = 0;
                end
            end else begin
                run_len[i] = 0;
            end
        end
        m_event = m_press | (ev_old & ~(i_clr_we ? i_clr_mask : '0));
        d2 = d1;
        d1 = i_btn;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_clear();
            else     model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            vectors++;
            if ({o_level, o_press, o_release, o_event, o_irq} !==
                {m_level, m_press, m_release, m_event, m_irq}) begin
                fails++;
                $display("FAIL model t=%0t lvl/prs/rel/ev/irq got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                         $time, o_level, o_press, o_release, o_event, o_irq,
                         m_level, m_press, m_release, m_event, m_irq);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %b want %b", name, act[N-1:0], exp[N-1:0]);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int hold [N];

    initial begin
        rst = 1'b1; i_btn = 5'b11111; i_clr_we = 1'b0; i_clr_mask = '0; i_irq_en = '0;
        tick(3);
        chk("reset_level", 32'(o_level), 32'd0);
        chk("reset_misc", 32'({o_press, o_release, o_event, o_irq}), 32'd0);
        rst = 1'b0;
        tick(5);
        chk("rst_rel_lvl_e4", 32'(o_level), 32'd0);
        tick(1);
        chk("rst_rel_lvl_e5", 32'(o_level), 32'b11111);
        chk("rst_rel_press_e5", 32'(o_press), 32'b11111);
        tick(1);
        chk("rst_rel_press_e6", 32'(o_press), 32'd0);
        chk("rst_rel_event", 32'(o_event), 32'b11111);
        i_btn = '0;
        tick(8);
        i_clr_we = 1'b1; i_clr_mask = 5'b11111;
        tick(1);
        i_clr_we = 1'b0;
        tick(2);
        chk("clear_all", 32'({o_event, o_irq}), 32'd0);

        // glitch of 3 input cycles on button 0
        i_btn[0] = 1'b1;
        tick(3);
        i_btn[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("glitch_ch0", 32'({o_level[0], o_press[0], o_event[0]}), 32'd0);
        end

        // press and release on button 2 with interrupt enabled
        i_irq_en = 5'b00100;
        i_btn[2] = 1'b1;
        tick(5);
        chk("ch2_press_e4", 32'(o_press), 32'd0);
        tick(1);
        chk("ch2_press_e5", 32'(o_press), 32'b00100);
        chk("ch2_event_e5", 32'(o_event), 32'b00100);
        chk("ch2_irq_e5", 32'(o_irq), 32'd0);
        tick(1);
        chk("ch2_irq_e6", 32'(o_irq), 32'd1);
        chk("ch2_press_e6", 32'(o_press), 32'd0);
        i_btn[2] = 1'b0;
        tick(5);
        chk("ch2_rel_e4", 32'(o_release), 32'd0);
        tick(1);
        chk("ch2_rel_e5", 32'(o_release), 32'b00100);
        chk("ch2_event_hold", 32'(o_event), 32'b00100);

        // software clear, then clear colliding with a new press
        i_clr_we = 1'b1; i_clr_mask = 5'b00100;
        tick(1);
        chk("clr_event", 32'(o_event), 32'd0);
        chk("clr_irq_lag", 32'(o_irq), 32'd1);
        i_clr_we = 1'b0;
        tick(1);
        chk("clr_irq", 32'(o_irq), 32'd0);
        i_btn[2] = 1'b1;
        tick(5);
        i_clr_we = 1'b1; i_clr_mask = 5'b00100;
        tick(1);
        chk("set_wins_press", 32'(o_press), 32'b00100);
        chk("set_wins_event", 32'(o_event), 32'b00100);
        i_clr_we = 1'b0;
        tick(1);
        chk("set_wins_hold", 32'(o_event), 32'b00100);
        i_btn[2] = 1'b0;
        tick(7);
        i_clr_we = 1'b1; i_clr_mask = 5'b11111;
        tick(1);
        i_clr_we = 1'b0; i_irq_en = '0;
        tick(2);

        // reset while channel 1 is mid-debounce
        i_btn[1] = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_level", 32'({o_level[1], o_press[1]}), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(5);
        chk("rst_mid_e4", 32'({o_level, o_press}), 32'd0);
        tick(1);
        chk("rst_mid_press", 32'(o_press), 32'b00010);
        chk("rst_mid_level_e5", 32'(o_level), 32'b00010);
        tick(1);

        // simultaneous rise on buttons 3 and 4
        i_btn = 5'b11010;
        tick(5);
        chk("dual_e4", 32'(o_press), 32'd0);
        tick(1);
        chk("dual_press", 32'(o_press), 32'b11000);
        chk("dual_release", 32'(o_release), 32'd0);
        tick(1);

        // randomized phase: mix of sub-threshold glitches and long holds
        for (int i = 0; i < N; i++) hold[i] = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                hold[i] = hold[i] - 1;
                if (hold[i] <= 0) begin
                    i_btn[i] = ~i_btn[i];
                    hold[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                         : int'($urandom_range(4, 12));
                end
            end
            i_clr_we   = ($urandom_range(0, 7) == 0);
            i_clr_mask = N'($urandom);
            if ($urandom_range(0, 31) == 0) i_irq_en = N'($urandom);
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
